bram_playback_seq: RTL and testbench

Sequential playback engine on the external (PHY-side) port of the Avalon-loaded dual-port block RAM. Software fills the RAM over the bus. This block reads a programmed window of words back at up to one word per clock and presents them as a valid/ready stream to the DAC datapath. It supports one-shot and continuous-loop playback, and tolerates downstream backpressure without losing or duplicating words.

---
 rtl/bram_playback_seq.sv | 165 ++++++++++++++++
 tb/tb_bram_playback_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_playback_seq.sv
// bram_playback_seq: reads a programmed window from the RAM external port at
// up to one word per clock and presents it as a valid/ready stream. A
// 2-entry output FIFO, together with a credit check on issue, absorbs the
// one-cycle RAM read latency under downstream backpressure.
module bram_playback_seq #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           word_count,
    output logic                  bram_rd_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;   // latched window start
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;   // next read address
    logic [ADDR_WIDTH:0]   len_q, len_d;     // latched window length
    logic [ADDR_WIDTH:0]   rem_q, rem_d;     // reads left in the current pass
    logic                  pend_q, pend_d;   // read issued last cycle, data due now
    logic                  done_q, done_d;
    logic [31:0]           wcnt_q, wcnt_d;

    // output FIFO: two data registers, one-bit pointers, occupancy count
    logic [DATA_WIDTH-1:0] ent0_q, ent1_q;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            cnt_q;

    logic       pop, push, flush, issue, accept, credit_ok;
    logic [2:0] occ;
    logic [1:0] cnt_after_pop;

    assign pop           = (cnt_q != 2'd0) && m_ready;
    assign push          = pend_q;
    assign flush         = stop && (state_q != S_IDLE);
    assign occ           = {1'b0, cnt_q} + {2'b00, pend_q};
    // occ >= pop always holds, since pop needs a non-empty FIFO
    assign credit_ok     = (occ - {2'b00, pop}) < 3'd2;
    assign issue         = (state_q == S_RUN) && credit_ok && !stop;
    assign accept        = (state_q == S_IDLE) && start && !stop && (length != '0);
    assign cnt_after_pop = cnt_q - {1'b0, pop};

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign word_count = wcnt_q;
    assign bram_rd_en = issue;
    assign bram_addr  = addr_q;
    assign m_valid    = (cnt_q != 2'd0);
    assign m_data     = rd_ptr_q ? ent1_q : ent0_q;

    // next-state: window sequencing, loop wrap, drain completion, abort
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        len_d   = len_q;
        rem_d   = rem_q;
        pend_d  = issue;
        done_d  = 1'b0;
        wcnt_d  = wcnt_q + {31'd0, pop};
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    base_d  = start_addr;
                    addr_d  = start_addr;
                    len_d   = length;
                    rem_d   = length;
                    wcnt_d  = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (issue) begin
                    addr_d = addr_q + ADDR_ONE;
                    rem_d  = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        if (loop_en) begin
                            addr_d = base_q;
                            rem_d  = len_q;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // leave as soon as this cycle's pop empties the FIFO, so done
                // lands on the cycle right after the last transfer
                if (stop) begin
                    state_d = S_IDLE;
                end else if (!pend_q && (cnt_after_pop == 2'd0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // control state registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // output FIFO: capture returning read data, advance head on pop, flush on stop
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr_q) ent1_q <= bram_rd_data;
                else          ent0_q <= bram_rd_data;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bram_playback_seq.sv
// Bench for bram_playback_seq: a transfer-level model (window base, length,
// counts of reads issued and words popped) checks every cycle; directed
// sequences pin the exact timing with literal expectations.
module tb_bram_playback_seq;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, bram_rd_en, m_valid;
    logic          m_ready = 1'b1;
    logic [31:0]   word_count;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_rd_data = '0;
    logic [DW-1:0] m_data;

    logic [DW-1:0] ram [DEPTH];

    int checks = 0;
    int errors = 0;

    bram_playback_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .resetn(resetn), .start(start), .stop(stop),
        .loop_en(loop_en), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .word_count(word_count),
        .bram_rd_en(bram_rd_en), .bram_addr(bram_addr),
        .bram_rd_data(bram_rd_data), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready)
    );

    always #5 clock = ~clock;

    // RAM external port: one-cycle read latency
    always @(posedge clock) if (bram_rd_en) bram_rd_data <= ram[bram_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          act = 0, m_loop = 0, exp_busy = 0, exp_done = 0, prev_stall = 0;
    int          m_base = 0, m_len = 1, n_iss = 0, n_pop = 0;
    logic [31:0] wc_exp = '0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clock) begin
        if (!resetn) begin
            act = 0; exp_busy = 0; exp_done = 0; wc_exp = '0;
            prev_stall = 0; n_iss = 0; n_pop = 0;
        end else begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("word_count", word_count, wc_exp);
            if (!act) begin
                chk("idle_rd_en", bram_rd_en, 0);
                chk("idle_valid", m_valid, 0);
            end else begin
                chk("occupancy_le_2", (n_iss - n_pop) <= 2, 1);
            end
            if (bram_rd_en && act) begin
                chk("rd_addr", bram_addr, (m_base + n_iss % m_len) % DEPTH);
                if (!m_loop) chk("rd_beyond_window", n_iss < m_len, 1);
                n_iss++;
            end
            if (m_valid && prev_stall) chk("stall_hold", m_data, prev_data);
            if (m_valid && m_ready && act) begin
                chk("m_data", m_data, ram[(m_base + n_pop % m_len) % DEPTH]);
                n_pop++;
                wc_exp = wc_exp + 1;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            exp_done = 0;
            if (!act && start && !stop && length != 0) begin
                act = 1; exp_busy = 1; m_base = int'(start_addr); m_len = int'(length);
                m_loop = loop_en; n_iss = 0; n_pop = 0; wc_exp = '0;
            end else if (act && stop) begin
                act = 0; exp_busy = 0;
            end else if (act && !m_loop && n_pop == m_len) begin
                act = 0; exp_busy = 0; exp_done = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input int base, input int len, input bit lp);
        start_addr = base[AW-1:0];
        length     = len[AW:0];
        loop_en    = lp;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, done, 1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] addrs[$];
        int cnt, seen;
        logic [AW-1:0] wrap_exp [4];

        for (int i = 0; i < DEPTH; i++) ram[i] = 32'h100 + i;

        // reset values
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_rd_en", bram_rd_en, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        resetn = 1'b1;
        tick(); tick();

        // one-shot, base 0x010, length 4: valid at T+3..T+6, done at T+7
        m_ready = 1'b1;
        pulse_start(32'h010, 4, 0);
        for (int c = 1; c <= 8; c++) begin
            chk("t1_busy", busy, (c >= 1 && c <= 6));
            chk("t1_valid", m_valid, (c >= 3 && c <= 6));
            chk("t1_done", done, (c == 7));
            if (c == 1) chk("t1_first_addr", {bram_rd_en, bram_addr}, {1'b1, 10'h010});
            if (c >= 3 && c <= 6) chk("t1_data", m_data, 32'h110 + c - 3);
            tick();
        end
        chk("t1_wc", word_count, 4);

        // address wrap
        pulse_start(32'h3FE, 4, 0);
        addrs.delete();
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bram_rd_en) addrs.push_back(bram_addr);
            if (done) seen = 1;
            tick();
        end
        chk("t2_done_seen", seen, 1);
        wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
        chk("t2_nreads", addrs.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t2_wrap_addr", (i < addrs.size()) ? addrs[i] : 10'h2AA, wrap_exp[i]);

        // random backpressure, length 64, random data and base
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
        pulse_start($urandom_range(0, DEPTH - 1), 64, 0);
        cnt = 0;
        while (!done && cnt < 2000) begin
            m_ready = $urandom_range(0, 1);
            tick();
            cnt++;
        end
        chk("t3_done_seen", done, 1);
        chk("t3_wc", word_count, 64);
        m_ready = 1'b1;
        tick();

        // continuous loop, length 3: 12 gapless words then stop
        pulse_start(32'h155, 3, 1);
        cnt = 0;
        while (!m_valid && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("t4_valid_seen", m_valid, 1);
        for (int k = 0; k < 12; k++) begin
            chk("t4_gapless", m_valid && m_ready, 1);
            chk("t4_pattern", m_data, ram[(32'h155 + k % 3) % DEPTH]);
            chk("t4_no_done", done, 0);
            tick();
        end
        pulse_stop();
        chk("t4_stop_valid", m_valid, 0);
        chk("t4_stop_busy", busy, 0);
        chk("t4_stop_done", done, 0);
        tick(); tick();

        // edge starts: zero length, start+stop, start while busy
        pulse_start(32'h020, 0, 0);
        for (int c = 0; c < 4; c++) begin
            chk("t5_len0_busy", busy, 0);
            chk("t5_len0_rd", bram_rd_en, 0);
            tick();
        end
        stop = 1'b1;
        pulse_start(32'h020, 5, 0);
        stop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("t5_ss_busy", busy, 0);
            chk("t5_ss_rd", bram_rd_en, 0);
            tick();
        end
        pulse_start(32'h100, 8, 0);
        tick();
        pulse_start(32'h200, 2, 0);
        wait_done(100, "t5_busy_start");
        chk("t5_busy_start_wc", word_count, 8);

        // asynchronous reset mid-run, then a full replay
        pulse_start(32'h0F0, 32, 0);
        for (int c = 0; c < 10; c++) tick();
        #2 resetn = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_wc", word_count, 0);
        chk("t6_rd_en", bram_rd_en, 0);
        chk("t6_addr", bram_addr, 0);
        chk("t6_valid", m_valid, 0);
        chk("t6_data", m_data, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        pulse_start(32'h0F0, 32, 0);
        wait_done(200, "t6_replay");
        chk("t6_replay_wc", word_count, 32);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
